// File: rtl/uart_alu_interface_pkg.sv
// uart_alu_interface_pkg: shared widths, FSM states and ALU opcodes for the UART-ALU datapath
package uart_alu_interface_pkg;
  localparam int DEF_NB_DATA      = 8;
  localparam int DEF_NB_OP        = 6;
  localparam int DEF_NB_TIMEOUT   = 16;
  localparam int DEF_TIMEOUT_CLKS = 50000;
  typedef enum logic [2:0] {ST_WAIT_A, ST_WAIT_B, ST_WAIT_OP, ST_EXEC, ST_SEND} state_t;
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_NOR = 6'h27;
endpackage

// File: rtl/uart_alu_interface_frame_timeout.sv
// frame_timeout: inter-byte counter that flags when a partial frame has idled for TIMEOUT_CLKS clocks
module frame_timeout #(
  parameter int NB_TIMEOUT   = 16,
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam logic [NB_TIMEOUT-1:0] LAST = NB_TIMEOUT'(TIMEOUT_CLKS - 1);
  logic [NB_TIMEOUT-1:0] cnt_q, cnt_d;
  // expiry fires on the clock that would bring the count to TIMEOUT_CLKS
  always_comb begin
    o_expired = i_enable && !i_clear && (cnt_q == LAST);
    cnt_d     = (i_clear || o_expired) ? '0 : i_enable ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) cnt_q <= '0;
    else          cnt_q <= cnt_d;
endmodule

// File: rtl/uart_alu_interface.sv
// uart_alu_interface: assembles A, B, opcode from rx bytes, drives the ALU and hands the result to tx
module uart_alu_interface import uart_alu_interface_pkg::*; #(
  parameter int NB_DATA      = DEF_NB_DATA,
  parameter int NB_OP        = DEF_NB_OP,
  parameter int NB_TIMEOUT   = DEF_NB_TIMEOUT,
  parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done_tick,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_overrun,
  output logic               o_timeout
);
  state_t             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, tx_data_q, tx_data_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               tx_start_q, tx_start_d, overrun_q, overrun_d, timeout_q, timeout_d;
  logic               collecting, expired;
  assign collecting = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
  frame_timeout #(.NB_TIMEOUT(NB_TIMEOUT), .TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timeout (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (i_rx_done_tick || !collecting),
    .i_enable (collecting),
    .o_expired(expired)
  );
  // expired is already masked by a same-cycle byte, so the byte always wins
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    overrun_d  = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      ST_WAIT_A:  if (i_rx_done_tick) begin a_d = i_rx_data; state_d = ST_WAIT_B; end
      ST_WAIT_B:  if (i_rx_done_tick) begin b_d = i_rx_data; state_d = ST_WAIT_OP; end
                  else if (expired) begin timeout_d = 1'b1; state_d = ST_WAIT_A; end
      ST_WAIT_OP: if (i_rx_done_tick) begin op_d = i_rx_data[NB_OP-1:0]; state_d = ST_EXEC; end
                  else if (expired) begin timeout_d = 1'b1; state_d = ST_WAIT_A; end
      ST_EXEC: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        overrun_d  = i_rx_done_tick;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        overrun_d = i_rx_done_tick;
        state_d   = i_tx_done_tick ? ST_WAIT_A : ST_SEND;
      end
      default: state_d = ST_WAIT_A;
    endcase
  end
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      state_q    <= ST_WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  assign o_alu_a    = a_q;
  assign o_alu_b    = b_q;
  assign o_alu_op   = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_overrun  = overrun_q;
  assign o_timeout  = timeout_q;
  assign o_busy     = (state_q == ST_EXEC) || (state_q == ST_SEND);
endmodule
